// File: rtl/bcd_convert_sched.sv
// Shared iterative double-dabble binary-to-BCD converter arbitrating between two requesters.
// Build option: define ARB_RR_EN for round-robin arbitration (default: requester 0 has fixed priority).
module bcd_convert_sched #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] binary0,
  input  logic [W-1:0] binary1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [3:0]   thos,
  output logic [3:0]   huns,
  output logic [3:0]   tens,
  output logic [3:0]   ones
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [1:0]    state;
  logic [W-1:0]  operand;
  logic [15:0]   scratch;
  logic [15:0]   adjusted;
  logic [15:0]   scratch_shifted;
  logic [CW-1:0] count;
  logic          served;
  logic          pick;
  logic          last_count;

`ifdef ARB_RR_EN
  // Index of the requester served most recently; it loses the next tie.
  logic last_served;

  always_comb begin
    if (req == 2'b11)
      pick = ~last_served;
    else
      pick = ~req[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_served <= 1'b1;
    else if (state == LOAD)
      last_served <= served;
  end
`else
  assign pick = ~req[0];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adjust
      assign adjusted[4*gi +: 4] = (scratch[4*gi +: 4] >= 4'd5) ?
                                   scratch[4*gi +: 4] + 4'd3 :
                                   scratch[4*gi +: 4];
    end
  endgenerate

  assign scratch_shifted = {adjusted[14:0], operand[W-1]};
  assign last_count      = (count == CW'(W - 1));
  assign busy            = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      done    <= 1'b0;
      done_id <= 1'b0;
      thos    <= 4'd0;
      huns    <= 4'd0;
      tens    <= 4'd0;
      ones    <= 4'd0;
      operand <= '0;
      scratch <= 16'd0;
      count   <= '0;
      served  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= LOAD;
            served <= pick;
            gnt    <= pick ? 2'b10 : 2'b01;
          end
        end
        LOAD: begin
          operand <= served ? binary1 : binary0;
          scratch <= 16'd0;
          count   <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          scratch <= scratch_shifted;
          operand <= {operand[W-2:0], 1'b0};
          count   <= count + 1'b1;
          // Final shift: publish the finished digits on the edge entering DONE.
          if (last_count) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= served;
            thos    <= scratch_shifted[15:12];
            huns    <= scratch_shifted[11:8];
            tens    <= scratch_shifted[7:4];
            ones    <= scratch_shifted[3:0];
          end
        end
        DONE: begin
          done  <= 1'b0;
          gnt   <= 2'b00;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
